// File: rtl/div_seq_unit.sv
// rtl/div_seq_unit.sv - iterative radix-2 restoring RV32M DIV/DIVU/REM/REMU unit
// Optional build macro DIV_FAST_SPECIAL_EN: finish divide-by-zero / signed overflow one cycle after start.
module div_seq_unit (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [1:0]  op_i,
   input  logic [31:0] rs1_data_i,
   input  logic [31:0] rs2_data_i,
   input  logic [4:0]  rd_addr_i,
   input  logic        kill_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        rd_wren_o,
   output logic [4:0]  rd_addr_o,
   output logic [31:0] rd_data_o
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] dvs_q, dvs_d;
   logic [31:0] rs1_q, rs1_d;
   logic        is_rem_q, is_rem_d;
   logic        qneg_q, qneg_d;
   logic        rneg_q, rneg_d;
   logic        dz_q, dz_d;
   logic        ovf_q, ovf_d;
   logic [4:0]  rd_addr_q, rd_addr_d;
   logic [4:0]  rd_out_q, rd_out_d;
   logic [31:0] rd_data_q, rd_data_d;

   logic        op_signed;
   logic [31:0] abs_a, abs_b;
   logic [32:0] shifted, trial;
   logic [31:0] quo_res, rem_res;
   logic        finish;

   assign op_signed = ~op_i[0];
   assign abs_a     = (op_signed && rs1_data_i[31]) ? 32'd0 - rs1_data_i : rs1_data_i;
   assign abs_b     = (op_signed && rs2_data_i[31]) ? 32'd0 - rs2_data_i : rs2_data_i;

   // Dividend bits stream out of quo's MSB into rem while quotient bits fill quo's LSB.
   assign shifted = {rem_q, quo_q[31]};
   assign trial   = shifted - {1'b0, dvs_q};

   always_comb begin
      quo_res = qneg_q ? 32'd0 - quo_q : quo_q;
      rem_res = rneg_q ? 32'd0 - rem_q : rem_q;
      if (dz_q) begin
         quo_res = 32'hFFFF_FFFF;
         rem_res = rs1_q;
      end else if (ovf_q) begin
         quo_res = 32'h8000_0000;
         rem_res = 32'd0;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      rs1_d     = rs1_q;
      is_rem_d  = is_rem_q;
      qneg_d    = qneg_q;
      rneg_d    = rneg_q;
      dz_d      = dz_q;
      ovf_d     = ovf_q;
      rd_addr_d = rd_addr_q;
      rd_out_d  = rd_out_q;
      rd_data_d = rd_data_q;
      finish    = 1'b0;

      if (kill_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  state_d   = S_CALC;
                  cnt_d     = 6'd32;
                  rem_d     = 32'd0;
                  quo_d     = abs_a;
                  dvs_d     = abs_b;
                  rs1_d     = rs1_data_i;
                  is_rem_d  = op_i[1];
                  qneg_d    = op_signed & (rs1_data_i[31] ^ rs2_data_i[31]);
                  rneg_d    = op_signed & rs1_data_i[31];
                  dz_d      = (rs2_data_i == 32'd0);
                  ovf_d     = op_signed && (rs1_data_i == 32'h8000_0000)
                              && (rs2_data_i == 32'hFFFF_FFFF);
                  rd_addr_d = rd_addr_i;
               end
            end
            S_CALC: begin
               if (cnt_q == 6'd0) begin
                  finish = 1'b1;
               end else begin
                  cnt_d = cnt_q - 6'd1;
                  if (!trial[32]) begin
                     rem_d = trial[31:0];
                     quo_d = {quo_q[30:0], 1'b1};
                  end else begin
                     rem_d = shifted[31:0];
                     quo_d = {quo_q[30:0], 1'b0};
                  end
               end
`ifdef DIV_FAST_SPECIAL_EN
               if (dz_q || ovf_q) finish = 1'b1;
`else
`endif
               if (finish) begin
                  state_d   = S_DONE;
                  rd_data_d = is_rem_q ? rem_res : quo_res;
                  rd_out_d  = rd_addr_q;
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         cnt_q     <= 6'd0;
         rem_q     <= 32'd0;
         quo_q     <= 32'd0;
         dvs_q     <= 32'd0;
         rs1_q     <= 32'd0;
         is_rem_q  <= 1'b0;
         qneg_q    <= 1'b0;
         rneg_q    <= 1'b0;
         dz_q      <= 1'b0;
         ovf_q     <= 1'b0;
         rd_addr_q <= 5'd0;
         rd_out_q  <= 5'd0;
         rd_data_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         rs1_q     <= rs1_d;
         is_rem_q  <= is_rem_d;
         qneg_q    <= qneg_d;
         rneg_q    <= rneg_d;
         dz_q      <= dz_d;
         ovf_q     <= ovf_d;
         rd_addr_q <= rd_addr_d;
         rd_out_q  <= rd_out_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign busy_o    = (state_q != S_IDLE);
   assign done_o    = (state_q == S_DONE);
   assign rd_wren_o = (state_q == S_DONE) && (rd_out_q != 5'd0);
   assign rd_addr_o = rd_out_q;
   assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_div_seq_unit.sv
// tb/tb_div_seq_unit.sv - scoreboard bench for div_seq_unit with directed vectors
module tb_div_seq_unit;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        start_i = 1'b0;
   logic [1:0]  op_i = 2'd0;
   logic [31:0] rs1_data_i = 32'd0;
   logic [31:0] rs2_data_i = 32'd0;
   logic [4:0]  rd_addr_i = 5'd0;
   logic        kill_i = 1'b0;
   logic        busy_o, done_o, rd_wren_o;
   logic [4:0]  rd_addr_o;
   logic [31:0] rd_data_o;

   localparam logic [1:0] DIV = 2'd0, DIVU = 2'd1, REM = 2'd2, REMU = 2'd3;
   localparam int NORM_LAT = 33;
`ifdef DIV_FAST_SPECIAL_EN
   localparam int SPEC_LAT = 1;
`else
   localparam int SPEC_LAT = 33;
`endif

   typedef struct {
      logic [31:0] data;
      logic [4:0]  addr;
      logic        wren;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   total = 0;
   int   passed = 0;

   div_seq_unit dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
      .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .rd_addr_i(rd_addr_i),
      .kill_i(kill_i), .busy_o(busy_o), .done_o(done_o), .rd_wren_o(rd_wren_o),
      .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Monitor: pops one expectation per done pulse.
   always @(negedge clk) begin
      if (!rst_i) begin
         if (done_o) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("rd_data", rd_data_o, e.data);
               check("rd_addr", {27'd0, rd_addr_o}, {27'd0, e.addr});
               check("rd_wren", {31'd0, rd_wren_o}, {31'd0, e.wren});
               check("done_cycle", 32'(cyc), 32'(e.cyc));
            end
         end else if (rd_wren_o) begin
            check("wren_without_done", 32'd1, 32'd0);
         end
      end
   end

   task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd);
      @(negedge clk);
      start_i = 1'b1; op_i = op; rs1_data_i = a; rs2_data_i = b; rd_addr_i = rd;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic expect_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, input logic [31:0] res, input int lat);
      exp_t e;
      @(negedge clk);
      e.data = res; e.addr = rd; e.wren = (rd != 5'd0); e.cyc = cyc + 1 + lat;
      sb.push_back(e);
      start_i = 1'b1; op_i = op; rs1_data_i = a; rs2_data_i = b; rd_addr_i = rd;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy_o && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", {31'd0, busy_o}, 32'd0);
   endtask

   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] res, input int lat);
      expect_op(op, a, b, rd, res, lat);
      wait_idle();
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      check("rst_done", {31'd0, done_o}, 32'd0);
      check("rst_wren", {31'd0, rd_wren_o}, 32'd0);
      check("rst_addr", {27'd0, rd_addr_o}, 32'd0);
      check("rst_data", rd_data_o, 32'd0);
      rst_i = 1'b0;

      run_op(DIV,  32'd20,        32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFFA, NORM_LAT);
      run_op(REM,  32'hFFFF_FFEC, 32'd3,         5'd6, 32'hFFFF_FFFE, NORM_LAT);
      run_op(DIVU, 32'hFFFF_FFFF, 32'd2,         5'd0, 32'h7FFF_FFFF, NORM_LAT);
      run_op(REMU, 32'hFFFF_FFFF, 32'd2,         5'd7, 32'd1,         NORM_LAT);
      run_op(DIVU, 32'd5,         32'd10,        5'd9, 32'd0,         NORM_LAT);
      run_op(DIV,  32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFD, NORM_LAT);
      run_op(REM,  32'd7,         32'hFFFF_FFFE, 5'd11, 32'd1,        NORM_LAT);

      run_op(DIV,  32'd7,         32'd0,         5'd8, 32'hFFFF_FFFF, SPEC_LAT);
      run_op(REM,  32'hFFFF_FFF9, 32'd0,         5'd8, 32'hFFFF_FFF9, SPEC_LAT);
      run_op(DIVU, 32'd7,         32'd0,         5'd8, 32'hFFFF_FFFF, SPEC_LAT);
      run_op(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, SPEC_LAT);
      run_op(REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0,        SPEC_LAT);

      // Kill at cycle 10 of CALC: no write-back, idle next cycle.
      start_op(DIVU, 32'd1000, 32'd3, 5'd4);
      repeat (9) @(negedge clk);
      kill_i = 1'b1;
      @(negedge clk);
      kill_i = 1'b0;
      check("kill_busy", {31'd0, busy_o}, 32'd0);
      repeat (40) @(negedge clk);
      run_op(DIVU, 32'd100, 32'd7, 5'd3, 32'd14, NORM_LAT);

      // Start during CALC is ignored.
      expect_op(DIV, 32'd20, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFFA, NORM_LAT);
      repeat (4) @(negedge clk);
      start_i = 1'b1; op_i = DIVU; rs1_data_i = 32'd1; rs2_data_i = 32'd1; rd_addr_i = 5'd2;
      @(negedge clk);
      start_i = 1'b0;
      wait_idle();

      // Asynchronous reset mid-CALC.
      start_op(DIVU, 32'd1000, 32'd3, 5'd4);
      repeat (7) @(negedge clk);
      #2 rst_i = 1'b1;
      #1;
      check("arst_busy", {31'd0, busy_o}, 32'd0);
      check("arst_done", {31'd0, done_o}, 32'd0);
      check("arst_wren", {31'd0, rd_wren_o}, 32'd0);
      check("arst_addr", {27'd0, rd_addr_o}, 32'd0);
      check("arst_data", rd_data_o, 32'd0);
      @(negedge clk);
      rst_i = 1'b0;
      run_op(REMU, 32'd100, 32'd7, 5'd13, 32'd2, NORM_LAT);

      repeat (3) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/div_seq_unit.md
# div_seq_unit

Iterative RV32M divide/remainder unit placed beside the ALU in the execute stage. It takes `rs1_data`/`rs2_data` as read from the register file and produces a single-cycle write-back request (`rd_wren`/`rd_addr`/`rd_data`) for the register-file write port. A new operation can start only when the unit is idle. Each operation is processed one quotient bit per cycle (radix-2 restoring).

## Interface
- No parameters; datapath fixed at 32 bits.
- `clk_i` in 1: clock; all state changes on the rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `start_i` in 1: request a new operation; accepted only when `busy_o`=0.
- `op_i` in 2: funct3[1:0] encoding.
  - 00 DIV
  - 01 DIVU
  - 10 REM
  - 11 REMU
- `rs1_data_i` in 32: dividend.
- `rs2_data_i` in 32: divisor.
- `rd_addr_i` in 5: destination register.
- `kill_i` in 1: synchronous abort (pipeline flush).
- `busy_o` out 1: high while in CALC or DONE.
- `done_o` out 1: one-cycle pulse; result valid.
- `rd_wren_o` out 1: `done_o` & (`rd_addr_o` != 0).
- `rd_addr_o` out 5: latched destination register.
- `rd_data_o` out 32: quotient or remainder.

## Operation
- States:
  - IDLE
  - CALC: 6-bit iteration counter.
  - DONE
- IDLE → CALC when `start_i` is high. On that edge, latch operands, op and rd_addr, and load the counter with 32.
- Signed ops (DIV, REM):
  - Divide the absolute values as unsigned. |0x80000000| = 0x80000000 as unsigned.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
- CALC, each cycle:
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor.
  - Set the quotient LSB when the result is ≥ 0, and restore the remainder otherwise.
  - Decrement the counter; at 1, go to DONE on the next edge with the sign-corrected result registered in `rd_data_o`.
- Divide-by-zero (rs2=0) overrides everything else:
  - Quotient = 0xFFFFFFFF for both DIV and DIVU.
  - Remainder = the original rs1.
- Overflow (DIV/REM, 0x80000000 / 0xFFFFFFFF):
  - Quotient = 0x80000000.
  - Remainder = 0.
- DONE lasts one cycle:
  - `done_o`=1.
  - `rd_wren_o` as defined above.
  - Returns to IDLE on the next edge.
- `kill_i` (any state) → IDLE on the next edge.
  - No `done_o`/`rd_wren_o` is produced for the killed op.
  - It overrides a simultaneous `start_i`: that start is not accepted.
- `start_i` while `busy_o`=1 is ignored. No queueing.
- An `rd_addr_i` of 0 still runs to completion: `done_o` pulses and `rd_wren_o` stays 0.

## Timing
- Reset values:
  - State IDLE.
  - `busy_o`, `done_o` and `rd_wren_o` = 0.
  - `rd_addr_o` = 0 and `rd_data_o` = 0.
- Asserting reset mid-operation aborts immediately and asynchronously; nothing is written back.
- Let E0 be the accepting edge.
- Normal path:
  - CALC spans the 32 cycles after E0.
  - DONE is entered at E33, so `done_o` is high from E33 to E34.
- `busy_o` rises at E0 and falls at E34. A new `start_i` can be accepted at E34.
- `rd_data_o` and `rd_addr_o` are registered and hold their value after DONE until the next result.
- Outputs depend only on registers; there are no combinational paths from inputs to outputs.

## Configuration
- `DIV_FAST_SPECIAL_EN` defined:
  - Divide-by-zero and signed overflow are detected at E0.
  - The unit skips CALC and enters DONE at E1 (`done_o` E1–E2).
- Not defined:
  - Every operation takes the full 33-cycle path.
  - Special-case results are applied at the CALC→DONE transition.
- Result values are identical in both builds; only latency differs.

## Test plan
- DIV 20 / −3 → 0xFFFFFFFA; REM −20 / 3 → 0xFFFFFFFE; `done_o` exactly at E33; `rd_wren_o` with rd=5.
- DIVU 0xFFFFFFFF / 2 → 0x7FFFFFFF; REMU 0xFFFFFFFF / 2 → 1; rd=0 → `done_o`=1, `rd_wren_o`=0.
- DIV 7/0 → 0xFFFFFFFF; REM −7/0 → 0xFFFFFFF9; DIV 0x80000000/−1 → 0x80000000; REM → 0.
  - With `DIV_FAST_SPECIAL_EN`: `done_o` at E1.
  - Without it: `done_o` at E33.
- `kill_i` at cycle 10 → no `done_o` or `rd_wren_o`, `busy_o`=0 next cycle; a new start of DIVU 100/7 → 14 at E33.
- `start_i` pulsed at cycle 5 of CALC with different operands → ignored; the original result is returned unchanged.
- `rst_i` asserted mid-CALC → all outputs 0 immediately; after release, REMU 100/7 → 2.
